multicycle_control_fsm: RTL and testbench

Multicycle sequencer for the MIPS core. It replaces the single-cycle combinational control unit when the datapath is refactored to a shared instruction/data memory with IR, MDR, A, B and ALUOut holding registers. It is a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back, and stalls on a memory-ready handshake. It drives every datapath mux select and write enable, and the ALU control decoder's `alu_op`.

---
 rtl/mips_mc_pkg.sv | 57 +++++
 rtl/multicycle_control_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// ALU-op codes and datapath select values.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_A      = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/write-back with a memory-ready stall.
//
// state     | meaning
// FETCH     | read IR from memory at PC, PC <= PC+4 on ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | ALUOut <= A + imm
// MEM_READ  | read MDR at ALUOut, wait for ready
// MEM_WB    | rt <= MDR
// MEM_WRITE | write B at ALUOut, wait for ready
// R_EXEC    | ALUOut <= A op B
// R_WB      | rd <= ALUOut
// I_EXEC    | ALUOut <= A op imm
// I_WB      | rt <= ALUOut
// BRANCH    | compare A,B; PC <= ALUOut when taken
// JUMP      | PC <= jump target
// JAL       | PC <= jump target, $31 <= PC
// JR        | PC <= A
module multicycle_control_fsm
    import mips_mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic [1:0] mem_to_reg_o,
    output logic [1:0] reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_op_o
);

    state_t     state;
    state_t     state_nxt;
    logic       ready;

    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;

    assign ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = S_FETCH;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = M2R_ALUOUT;
        reg_dst    = DST_RT;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_source  = PCS_ALU;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = ready;
                pc_write  = ready;
                state_nxt = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode_i)
                    OP_LW, OP_SW:    state_nxt = S_MEM_ADDR;
                    OP_RTYPE:        state_nxt = (funct_i == FUNCT_JR) ? S_JR : S_R_EXEC;
                    OP_ADDI, OP_ORI: state_nxt = S_I_EXEC;
                    OP_BEQ, OP_BNE:  state_nxt = S_BRANCH;
                    OP_J:            state_nxt = S_JUMP;
                    OP_JAL:          state_nxt = S_JAL;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_nxt = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read  = 1'b1;
                iord      = 1'b1;
                state_nxt = ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = ready;
                state_nxt  = ready ? S_FETCH : S_MEM_WRITE;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_nxt = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = DST_RD;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
                state_nxt = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_source  = PCS_ALUOUT;
                pc_write   = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                reg_write  = 1'b1;
                reg_dst    = DST_RA;
                mem_to_reg = M2R_PC;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_write   = 1'b1;
                pc_source  = PCS_A;
                instr_done = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // The state register already sits in FETCH during reset; gating keeps
    // FETCH's read strobe and selects from leaking out while held.
    assign pc_write_o   = reset & pc_write;
    assign ir_write_o   = reset & ir_write;
    assign iord_o       = reset & iord;
    assign mem_read_o   = reset & mem_read;
    assign mem_write_o  = reset & mem_write;
    assign mem_to_reg_o = reset ? mem_to_reg : 2'b00;
    assign reg_dst_o    = reset ? reg_dst : 2'b00;
    assign reg_write_o  = reset & reg_write;
    assign alu_src_a_o  = reset & alu_src_a;
    assign alu_src_b_o  = reset ? alu_src_b : 2'b00;
    assign alu_op_o     = reset ? alu_op : 3'b000;
    assign pc_source_o  = reset ? pc_source : 2'b00;
    assign instr_done_o = reset & instr_done;
    assign illegal_op_o = reset & illegal_op;
    assign state_o      = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into an
// expected per-cycle trace of state and control outputs, then replayed.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic       alu_src_a, instr_done, illegal_op;
    logic [1:0] mem_to_reg, reg_dst, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .pc_write_o   (pc_write),
        .ir_write_o   (ir_write),
        .iord_o       (iord),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_to_reg_o (mem_to_reg),
        .reg_dst_o    (reg_dst),
        .reg_write_o  (reg_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .pc_source_o  (pc_source),
        .state_o      (state),
        .instr_done_o (instr_done),
        .illegal_op_o (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [19:0] ctl;
        logic        rdy;
    } cyc_t;

    cyc_t trace[$];
    logic [19:0] obs;

    assign obs = {pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};

    function automatic logic [19:0] mk(input logic pcw, input logic irw, input logic io,
                                       input logic mrd, input logic mwr, input logic [1:0] m2r,
                                       input logic [1:0] dst, input logic rw, input logic a,
                                       input logic [1:0] b, input logic [2:0] aop,
                                       input logic [1:0] pcs, input logic done, input logic ill);
        return {pcw, irw, io, mrd, mwr, m2r, dst, rw, a, b, aop, pcs, done, ill};
    endfunction

    task automatic push(input logic [3:0] st, input logic [19:0] ctl, input logic rdy);
        cyc_t c;
        c.st  = st;
        c.ctl = ctl;
        c.rdy = rdy;
        trace.push_back(c);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction-level reference: expected state numbers and control per cycle.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int wf, input int wm);
        logic legal;
        trace.delete();
        for (int i = 0; i < wf; i++)
            push(4'd0, mk(0,0,0,1,0, 2'd0,2'd0, 0,0, 2'd1, 3'd0, 2'd0, 0,0), 1'b0);
        push(4'd0, mk(1,1,0,1,0, 2'd0,2'd0, 0,0, 2'd1, 3'd0, 2'd0, 0,0), 1'b1);
        legal = (op == 6'h00 || op == 6'h02 || op == 6'h03 || op == 6'h04 || op == 6'h05 ||
                 op == 6'h08 || op == 6'h0D || op == 6'h23 || op == 6'h2B);
        if (!legal) begin
            push(4'd1, mk(0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd3, 3'd0, 2'd0, 1,1), rnd_bit());
            return;
        end
        push(4'd1, mk(0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd3, 3'd0, 2'd0, 0,0), rnd_bit());
        if (op == 6'h23 || op == 6'h2B) begin
            push(4'd2, mk(0,0,0,0,0, 2'd0,2'd0, 0,1, 2'd2, 3'd0, 2'd0, 0,0), rnd_bit());
            if (op == 6'h23) begin
                for (int i = 0; i < wm; i++)
                    push(4'd3, mk(0,0,1,1,0, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd0, 0,0), 1'b0);
                push(4'd3, mk(0,0,1,1,0, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd0, 0,0), 1'b1);
                push(4'd4, mk(0,0,0,0,0, 2'd1,2'd0, 1,0, 2'd0, 3'd0, 2'd0, 1,0), rnd_bit());
            end else begin
                for (int i = 0; i < wm; i++)
                    push(4'd5, mk(0,0,1,0,1, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd0, 0,0), 1'b0);
                push(4'd5, mk(0,0,1,0,1, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd0, 1,0), 1'b1);
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            push(4'd13, mk(1,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd3, 1,0), rnd_bit());
        end else if (op == 6'h00) begin
            push(4'd6, mk(0,0,0,0,0, 2'd0,2'd0, 0,1, 2'd0, 3'd2, 2'd0, 0,0), rnd_bit());
            push(4'd7, mk(0,0,0,0,0, 2'd0,2'd1, 1,0, 2'd0, 3'd0, 2'd0, 1,0), rnd_bit());
        end else if (op == 6'h08 || op == 6'h0D) begin
            push(4'd8, mk(0,0,0,0,0, 2'd0,2'd0, 0,1, 2'd2, (op == 6'h0D) ? 3'd3 : 3'd0, 2'd0, 0,0),
                 rnd_bit());
            push(4'd9, mk(0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd0, 3'd0, 2'd0, 1,0), rnd_bit());
        end else if (op == 6'h04 || op == 6'h05) begin
            push(4'd10, mk((op == 6'h04) ? z : ~z, 0,0,0,0, 2'd0,2'd0, 0,1, 2'd0, 3'd1, 2'd1, 1,0),
                 rnd_bit());
        end else if (op == 6'h02) begin
            push(4'd11, mk(1,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 3'd0, 2'd2, 1,0), rnd_bit());
        end else begin
            push(4'd12, mk(1,0,0,0,0, 2'd2,2'd2, 1,0, 2'd0, 3'd0, 2'd2, 1,0), rnd_bit());
        end
    endtask

    task automatic check_cycle(input string tag, input logic [3:0] st_e, input logic [19:0] ctl_e);
        total++;
        assert (state === st_e) else begin
            bad++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, state, st_e);
        end
        total++;
        assert (obs === ctl_e) else begin
            bad++;
            $error("FAIL %s ctl: observed=%b expected=%b", tag, obs, ctl_e);
        end
    endtask

    // Replay up to 'limit' cycles of the built trace (negative = all).
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int wf, input int wm, input int limit);
        int n;
        build(op, fn, z, wf, wm);
        n = (limit < 0 || limit > trace.size()) ? trace.size() : limit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                opcode = op;
                funct  = fn;
                zero   = z;
            end
            mem_ready = trace[i].rdy;
            #1;
            check_cycle($sformatf("%s c%0d", name, i), trace[i].st, trace[i].ctl);
        end
    endtask

    logic [5:0] op_pool [10];

    initial begin
        op_pool = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
        reset = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        mem_ready = 1'b1;
        #3;
        check_cycle("reset_init", 4'd0, 20'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        run("add",     6'h00, 6'h20, 1'b0, 0, 0, -1);
        run("lw_wait", 6'h23, 6'h11, 1'b0, 2, 3, -1);
        run("beq_t",   6'h04, 6'h00, 1'b1, 0, 0, -1);
        run("beq_nt",  6'h04, 6'h00, 1'b0, 0, 0, -1);
        run("bne_t",   6'h05, 6'h00, 1'b0, 0, 0, -1);
        run("bne_nt",  6'h05, 6'h00, 1'b1, 1, 0, -1);
        run("jal",     6'h03, 6'h08, 1'b0, 0, 0, -1);
        run("jr",      6'h00, 6'h08, 1'b0, 0, 0, -1);
        run("illegal", 6'h3F, 6'h00, 1'b0, 0, 0, -1);
        run("sw",      6'h2B, 6'h00, 1'b0, 0, 2, -1);
        run("addi",    6'h08, 6'h00, 1'b0, 0, 0, -1);
        run("ori",     6'h0D, 6'h00, 1'b0, 0, 0, -1);
        run("j",       6'h02, 6'h00, 1'b0, 0, 0, -1);

        // Abort in the middle of a stalled store.
        run("sw_abort", 6'h2B, 6'h00, 1'b0, 0, 3, 4);
        #2 reset = 1'b0;
        #1 check_cycle("abort_now", 4'd0, 20'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 check_cycle("abort_hold", 4'd0, 20'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        run("after_abort", 6'h00, 6'h22, 1'b0, 0, 0, -1);

        for (int k = 0; k < 40; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 9)];
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            run($sformatf("rnd%0d", k), op, fn, rnd_bit(), $urandom_range(0, 3),
                $urandom_range(0, 3), -1);
        end

        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        assert (state === 4'd0) else begin
            bad++;
            $error("FAIL final_fetch: observed=%0d expected=0", state);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
